// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the NES OAM/DMC DMA controller.
// Holds the FSM state enum, default bus addresses and rw encoding.
package nes_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
`ifdef NES_DMA_DMC_CHANNEL_EN
    S_WRITE,
    S_DMC_RD
`else
    S_WRITE
`endif
  } dma_state_t;

  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DEST_ADDR_DEF = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dma_parity.sv
// Free-running get/put cycle parity for the DMA controller.
// Ports: clk, rst_n (sync, active-low), parity (toggles every cycle).
module dma_parity (
  input  logic clk,
  input  logic rst_n,
  output logic parity
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
    end
  end

endmodule

// File: rtl/nes_dma_ctrl.sv
// NES OAM sprite DMA controller; optional DMC sample-fetch channel
// under macro NES_DMA_DMC_CHANNEL_EN.
// Ports: clk, rst_n (sync, active-low), address_in/we_in/data_in
// (CPU bus), cpu_stall, address_out/data_out/rw_out (DMA bus);
// with the macro also dmc_req/dmc_addr in and dmc_ack/dmc_data out.
module nes_dma_ctrl
  import nes_dma_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          XFER_LEN  = 256,
  parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
  parameter logic [15:0] DEST_ADDR = DEST_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       address_in,
  input  logic              we_in,
  input  logic [DATA_W-1:0] data_in,
`ifdef NES_DMA_DMC_CHANNEL_EN
  input  logic              dmc_req,
  input  logic [15:0]       dmc_addr,
  output logic              dmc_ack,
  output logic [DATA_W-1:0] dmc_data,
`endif
  output logic              cpu_stall,
  output logic [15:0]       address_out,
  output logic [DATA_W-1:0] data_out,
  output logic              rw_out
);

  localparam logic [7:0] LAST = 8'(XFER_LEN - 1);

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;
  logic       parity;
  logic       trig;

`ifdef NES_DMA_DMC_CHANNEL_EN
  // dmc_go: current HALT belongs to a DMC fetch.
  // oam: an OAM transfer is latched or running.
  // run: OAM is past its HALT, so a DMC fetch
  // resumes via ALIGN instead of a fresh HALT.
  logic dmc_go;
  logic oam;
  logic run;
`endif

  assign trig = we_in && (address_in == TRIG_ADDR);

  dma_parity u_parity (
    .clk    (clk),
    .rst_n  (rst_n),
    .parity (parity)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      page        <= '0;
      idx         <= '0;
      cpu_stall   <= 1'b0;
      address_out <= '0;
      data_out    <= '0;
      rw_out      <= RW_READ;
`ifdef NES_DMA_DMC_CHANNEL_EN
      dmc_go      <= 1'b0;
      oam         <= 1'b0;
      run         <= 1'b0;
      dmc_ack     <= 1'b0;
      dmc_data    <= '0;
`endif
    end else begin
`ifdef NES_DMA_DMC_CHANNEL_EN
      dmc_ack <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          idx <= '0;
          if (trig) page <= data_in[7:0];
`ifdef NES_DMA_DMC_CHANNEL_EN
          dmc_go <= dmc_req;
          oam    <= trig;
          run    <= 1'b0;
          if (trig || dmc_req) begin
`else
          if (trig) begin
`endif
            state       <= S_HALT;
            cpu_stall   <= 1'b1;
            address_out <= address_in;
            rw_out      <= RW_READ;
          end
        end

        S_HALT: begin
          rw_out <= RW_READ;
`ifdef NES_DMA_DMC_CHANNEL_EN
          dmc_go <= 1'b0;
          run    <= !dmc_go;
          if (dmc_go || (dmc_req && !parity)) begin
            state       <= S_DMC_RD;
            address_out <= dmc_addr;
          end else
`endif
          if (parity) begin
            state <= S_ALIGN;
          end else begin
            state       <= S_READ;
            address_out <= {page, idx};
          end
        end

        S_ALIGN: begin
          state       <= S_READ;
          address_out <= {page, idx};
          rw_out      <= RW_READ;
        end

        S_READ: begin
          state       <= S_WRITE;
          address_out <= DEST_ADDR;
          data_out    <= data_in;
          rw_out      <= RW_WRITE;
        end

        S_WRITE: begin
          rw_out <= RW_READ;
          idx    <= idx + 8'd1;
          if (idx == LAST) begin
            state       <= S_IDLE;
            cpu_stall   <= 1'b0;
            address_out <= '0;
            data_out    <= '0;
            idx         <= '0;
`ifdef NES_DMA_DMC_CHANNEL_EN
            oam         <= 1'b0;
            run         <= 1'b0;
`endif
          end
`ifdef NES_DMA_DMC_CHANNEL_EN
          else if (dmc_req) begin
            state       <= S_DMC_RD;
            address_out <= dmc_addr;
          end
`endif
          else begin
            state       <= S_READ;
            address_out <= {page, idx + 8'd1};
          end
        end

`ifdef NES_DMA_DMC_CHANNEL_EN
        S_DMC_RD: begin
          dmc_ack  <= 1'b1;
          dmc_data <= data_in;
          rw_out   <= RW_READ;
          if (run) begin
            state <= S_ALIGN;
          end else if (oam) begin
            state <= S_HALT;
          end else begin
            state       <= S_IDLE;
            cpu_stall   <= 1'b0;
            address_out <= '0;
            data_out    <= '0;
          end
        end
`endif

        default: begin
          state       <= S_IDLE;
          cpu_stall   <= 1'b0;
          address_out <= '0;
          data_out    <= '0;
          rw_out      <= RW_READ;
        end
      endcase
    end
  end

endmodule

// File: doc/nes_dma_ctrl.md
NES_DMA_CTRL -- requirements
Module: nes_dma_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, CPU data bus width.
REQ-002 SHALL have parameter XFER_LEN, default 256, bytes per OAM transfer (power of two, 2..256).
REQ-003 SHALL have parameter TRIG_ADDR, default 16'h4014, CPU write address that starts OAM DMA.
REQ-004 SHALL have parameter DEST_ADDR, default 16'h2004, destination address for every OAM write.
REQ-005 SHALL have port clk  input  1  system clock; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port address_in  input  16  CPU bus address.
REQ-008 SHALL have port we_in  input  1  CPU write strobe.
REQ-009 SHALL have port data_in  input  DATA_W  CPU write data / DMA read return data.
REQ-010 SHALL have port cpu_stall  output  1  high while the DMA owns the bus.
REQ-011 SHALL have port address_out  output  16  DMA bus address.
REQ-012 SHALL have port data_out  output  DATA_W  DMA write data.
REQ-013 SHALL have port rw_out  output  1  1 = read, 0 = write.
REQ-014 SHALL have, under DMC_CHANNEL_EN only, ports dmc_req (in, 1), dmc_addr (in, 16), dmc_ack (out, 1) and dmc_data (out, DATA_W).

Function
REQ-015 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE and, with the macro, DMC_RD.
REQ-016 SHALL start a transfer when we_in=1 and address_in=TRIG_ADDR in IDLE, latching data_in[7:0] as page.
REQ-017 SHALL assert cpu_stall on the cycle after the trigger and hold it until the final WRITE completes.
REQ-018 SHALL spend one cycle in HALT with rw_out=1 and address_out=last address_in.
REQ-019 SHALL toggle a free-running parity bit every cycle from reset, and insert one ALIGN cycle when HALT falls on an odd cycle.
REQ-020 SHALL, in READ, drive address_out={page,idx} with rw_out=1, capture data_in at the end of the cycle and go to WRITE.
REQ-021 SHALL, in WRITE, drive address_out=DEST_ADDR, data_out=captured byte and rw_out=0, then increment idx.
REQ-022 SHALL return to IDLE after the WRITE with idx=XFER_LEN-1, deasserting cpu_stall that same edge: total stall 1+2*XFER_LEN cycles, plus 1 when odd.
REQ-023 SHALL ignore triggers while not in IDLE.
REQ-024 SHALL wrap address bits only within the page: page 8'hFF reads 16'hFF00..FF(XFER_LEN-1).
REQ-025 SHALL drive address_out=0, data_out=0 and rw_out=1 in IDLE.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge, clear state to IDLE, idx, page and parity to 0, cpu_stall to 0, address_out to 0, data_out to 0, rw_out to 1 and dmc_ack to 0, including mid-transfer.

Configuration
REQ-027 SHALL use the macro NES_DMA_DMC_CHANNEL_EN to compile the DMC channel in; without it the DMC ports and the DMC_RD state are absent.
REQ-028 SHALL, with the macro and dmc_req=1 during IDLE, stall for one HALT cycle and then one DMC_RD cycle.
REQ-029 SHALL, in DMC_RD, drive address_out=dmc_addr with rw_out=1, and pulse dmc_ack for one cycle with dmc_data=data_in.
REQ-030 SHALL, with dmc_req=1 when OAM would enter READ, run DMC_RD followed by one ALIGN cycle, then resume READ at the same idx (+2 cycles).
REQ-031 SHALL give a DMC request priority over a simultaneous trigger; the trigger is still latched and runs afterwards.

Structure
REQ-032 SHALL place the state enum, the default TRIG_ADDR/DEST_ADDR constants and the rw encoding constants in package nes_dma_pkg.
REQ-033 SHALL implement the parity toggle as sub-module dma_parity.

Verification
REQ-034 SHALL cover: trigger 8'h55 with HALT on an even cycle -> reads 5500..55FF, 256 writes to 2004 with matching data, cpu_stall high for 513 cycles.
REQ-035 SHALL cover: the same trigger with HALT on an odd cycle -> cpu_stall high for 514 cycles with one ALIGN.
REQ-036 SHALL cover: a second 4014 write at byte 20 -> ignored; page stays 8'h55 and the count is unchanged.
REQ-037 SHALL cover: rst_n=0 at byte 10 -> next cycle cpu_stall=0, address_out=0, rw_out=1, and a new trigger restarts at idx 0.
REQ-038 SHALL cover, with the macro: dmc_req with dmc_addr=C000 at byte 100 -> one read of C000, a one-cycle dmc_ack, OAM resuming at 55(100), and stall +2.
REQ-039 SHALL cover: XFER_LEN=4 with page FF -> reads FF00..FF03 only, and cpu_stall high for 9 or 10 cycles.
